// File: rtl/traffic_phase_ctrl.sv
// Demand-actuated round-robin traffic-light sequencer with rest-in-green.
// Optional flash mode is compiled in with `define TLC_FLASH_EN (adds the `flash` input).
module traffic_phase_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       hold,
  input  logic       clr,
  input  logic [1:0] lamp_nxt,
  output logic       demand,
  output logic [1:0] lamp
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      demand <= 1'b0;
      lamp   <= 2'b10;
    end else begin
      if (clr)              demand <= 1'b0;
      else if (req && !hold) demand <= 1'b1;
      lamp <= lamp_nxt;
    end
  end
endmodule

module traffic_phase_ctrl #(
  parameter int NUM_PHASES  = 2,
  parameter int TIMER_W     = 8,
  parameter int T_ALLRED    = 2,
  parameter int T_REDYELLOW = 2,
  parameter int T_GREEN_MIN = 10,
  parameter int T_YELLOW    = 3,
  parameter int FLASH_HALF  = 4,
  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
`ifdef TLC_FLASH_EN
  input  logic                    flash,
`endif
  input  logic [NUM_PHASES-1:0]   req,
  output logic [2*NUM_PHASES-1:0] lights,
  output logic [2:0]              state_code,
  output logic [PH_W-1:0]         phase
);
  localparam logic [2:0] S_ALL_RED    = 3'd0;
  localparam logic [2:0] S_RED_YELLOW = 3'd1;
  localparam logic [2:0] S_GREEN      = 3'd2;
  localparam logic [2:0] S_YELLOW     = 3'd3;
  localparam logic [2:0] S_FLASH      = 3'd4;

  localparam logic [1:0] C_GREEN  = 2'b00;
  localparam logic [1:0] C_YELLOW = 2'b01;
  localparam logic [1:0] C_RED    = 2'b10;
  localparam logic [1:0] C_RY     = 2'b11;

  // A zero duration behaves like one cycle.
  localparam logic [TIMER_W-1:0] LD_AR = TIMER_W'((T_ALLRED    > 1) ? T_ALLRED    - 1 : 0);
  localparam logic [TIMER_W-1:0] LD_RY = TIMER_W'((T_REDYELLOW > 1) ? T_REDYELLOW - 1 : 0);
  localparam logic [TIMER_W-1:0] LD_GR = TIMER_W'((T_GREEN_MIN > 1) ? T_GREEN_MIN - 1 : 0);
  localparam logic [TIMER_W-1:0] LD_YE = TIMER_W'((T_YELLOW    > 1) ? T_YELLOW    - 1 : 0);
  localparam logic [TIMER_W-1:0] LD_FL = TIMER_W'((FLASH_HALF  > 1) ? FLASH_HALF  - 1 : 0);

  function automatic logic [TIMER_W-1:0] ld(input logic [2:0] st);
    case (st)
      S_RED_YELLOW: return LD_RY;
      S_GREEN:      return LD_GR;
      S_YELLOW:     return LD_YE;
      S_FLASH:      return LD_FL;
      default:      return LD_AR;
    endcase
  endfunction

  function automatic logic [1:0] lamp_of(input logic [2:0] st, input logic mine, input logic fy);
    case (st)
      S_RED_YELLOW: return mine ? C_RY : C_RED;
      S_GREEN:      return mine ? C_GREEN : C_RED;
      S_YELLOW:     return mine ? C_YELLOW : C_RED;
      S_FLASH:      return fy ? C_YELLOW : C_RED;
      default:      return C_RED;
    endcase
  endfunction

  logic [2:0]                  state, state_nxt;
  logic [TIMER_W-1:0]          timer, timer_nxt;
  logic [PH_W-1:0]             phase_nxt, rr_next;
  logic                        move, tz, other_dem, fy_nxt;
  logic [NUM_PHASES-1:0]       demand, dem_hold, dem_clr;
  logic [NUM_PHASES-1:0][1:0]  lamp;

  assign tz         = (timer == '0);
  assign state_code = state;
  assign lights     = lamp;

  always_comb begin : rr
    int  idx;
    logic found;
    rr_next   = phase;
    found     = 1'b0;
    other_dem = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++)
      if (demand[i] && i != int'(phase)) other_dem = 1'b1;
    // Search p+1, p+2, ... wrapping back to p itself last.
    for (int k = 1; k <= NUM_PHASES; k++) begin
      idx = (int'(phase) + k) % NUM_PHASES;
      if (!found && demand[idx]) begin
        rr_next = PH_W'(idx);
        found   = 1'b1;
      end
    end
  end

`ifdef TLC_FLASH_EN
  logic flash_y;
`endif

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    move      = 1'b0;
`ifdef TLC_FLASH_EN
    fy_nxt    = flash_y;
`endif
    if (go) begin
      case (state)
        S_ALL_RED:    if (tz) begin state_nxt = S_RED_YELLOW; move = 1'b1; end
        S_RED_YELLOW: if (tz) begin state_nxt = S_GREEN;      move = 1'b1; end
        S_GREEN:      if (tz && other_dem) begin state_nxt = S_YELLOW; move = 1'b1; end
        S_YELLOW:     if (tz) begin
                        state_nxt = S_ALL_RED;
                        phase_nxt = rr_next;
                        move      = 1'b1;
                      end
        default:      begin
                        state_nxt = S_ALL_RED;
                        phase_nxt = '0;
                        move      = 1'b1;
                      end
      endcase
`ifdef TLC_FLASH_EN
      if (state == S_FLASH) begin
        state_nxt = S_FLASH;
        phase_nxt = phase;
        move      = 1'b0;
        if (!flash) begin
          state_nxt = S_ALL_RED;
          phase_nxt = '0;
          move      = 1'b1;
        end else if (tz) begin
          fy_nxt = !flash_y;
          move   = 1'b1;
        end
      end else if (flash) begin
        state_nxt = S_FLASH;
        phase_nxt = phase;
        fy_nxt    = 1'b1;
        move      = 1'b1;
      end
`endif
    end
    // Resting in Green leaves the timer parked at zero.
    if (move)           timer_nxt = ld(state_nxt);
    else if (go && !tz) timer_nxt = timer - TIMER_W'(1);
    else                timer_nxt = timer;
  end

`ifndef TLC_FLASH_EN
  assign fy_nxt = 1'b0;
`endif

  always_comb begin
    dem_hold = '0;
    dem_clr  = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      dem_hold[i] = (phase == PH_W'(i)) && (state == S_RED_YELLOW || state == S_GREEN);
      dem_clr[i]  = (phase == PH_W'(i)) && (state == S_RED_YELLOW) && (state_nxt == S_GREEN);
`ifdef TLC_FLASH_EN
      if (state == S_FLASH || state_nxt == S_FLASH) dem_clr[i] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_ALL_RED;
      timer <= LD_AR;
      phase <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      phase <= phase_nxt;
    end
  end

`ifdef TLC_FLASH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flash_y <= 1'b0;
    else      flash_y <= fy_nxt;
  end
`endif

  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_lane
    logic mine_nxt;
    assign mine_nxt = (phase_nxt == PH_W'(i));
    traffic_phase_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .req      (req[i]),
      .hold     (dem_hold[i]),
      .clr      (dem_clr[i]),
      .lamp_nxt (lamp_of(state_nxt, mine_nxt, fy_nxt)),
      .demand   (demand[i]),
      .lamp     (lamp[i])
    );
  end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: 2-phase and 4-phase instances plus a safety monitor.
module tb_traffic_phase_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       go  = 1'b1;
  logic       flash = 1'b0;
  logic [1:0] req  = '0;
  logic [3:0] req4 = '0;
  logic [3:0] lights;
  logic [7:0] lights4;
  logic [2:0] state_code, state4;
  logic       phase;
  logic [1:0] phase4;
  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk(clk), .rst(rst), .go(go),
`ifdef TLC_FLASH_EN
    .flash(flash),
`endif
    .req(req), .lights(lights), .state_code(state_code), .phase(phase)
  );

  traffic_phase_ctrl #(.NUM_PHASES(4)) dut4 (
    .clk(clk), .rst(rst), .go(go),
`ifdef TLC_FLASH_EN
    .flash(flash),
`endif
    .req(req4), .lights(lights4), .state_code(state4), .phase(phase4)
  );

  // Safety monitor: at most one non-Red lamp (outside flash) and no Red->Green step.
  logic [3:0] prev2 = 4'b1010;
  logic [7:0] prev4 = 8'hAA;
  always @(negedge clk) begin : mon
    int  nr2, nr4;
    logic bad;
    nr2 = 0; nr4 = 0; bad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (lights[2*i+:2] != 2'b10) nr2++;
      if (prev2[2*i+:2] == 2'b10 && lights[2*i+:2] == 2'b00) bad = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (lights4[2*i+:2] != 2'b10) nr4++;
      if (prev4[2*i+:2] == 2'b10 && lights4[2*i+:2] == 2'b00) bad = 1'b1;
    end
    if (state_code != 3'd4 && nr2 > 1) bad = 1'b1;
    if (state4 != 3'd4 && nr4 > 1) bad = 1'b1;
    ncmp++;
    if (bad) begin
      nbad++;
      $display("FAIL safety t=%0t lights=%b prev=%b lights4=%b prev4=%b, want <=1 non-Red and no Red->Green",
               $time, lights, prev2, lights4, prev4);
    end
    prev2 = lights;
    prev4 = lights4;
  end

  task automatic do_reset(input logic [1:0] r2, input logic [3:0] r4);
    rst = 1'b0; go = 1'b1; flash = 1'b0; req = r2; req4 = r4;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; go = 1'b1; req = 2'b11; req4 = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    ncmp++;
    if (lights !== 4'b1010 || state_code !== 3'd0 || phase !== 1'b0 || lights4 !== 8'hAA || phase4 !== 2'd0) begin
      nbad++;
      $display("FAIL reset: lights=%b state=%0d phase=%0d lights4=%h phase4=%0d, want 1010/0/0/aa/0",
               lights, state_code, phase, lights4, phase4);
    end
  endtask

  task automatic test_rest_green();
    int         ed[6] = '{1, 2, 3, 4, 20, 40};
    logic [3:0] el[6] = '{4'b1010, 4'b1011, 4'b1011, 4'b1000, 4'b1000, 4'b1000};
    logic [2:0] es[6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
    int j = 0;
    do_reset(2'b00, 4'h0);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (j < 6 && e == ed[j]) begin
        ncmp++;
        if (lights !== el[j] || state_code !== es[j] || phase !== 1'b0) begin
          nbad++;
          $display("FAIL rest_green edge %0d: lights=%b state=%0d phase=%0d, want %b/%0d/0",
                   e, lights, state_code, phase, el[j], es[j]);
        end
        j++;
      end
    end
  endtask

  task automatic test_demand_switch();
    int         ed[9] = '{13, 14, 16, 17, 18, 19, 20, 21, 30};
    logic [3:0] el[9] = '{4'b1000, 4'b1001, 4'b1001, 4'b1010, 4'b1010, 4'b1110, 4'b1110, 4'b0010, 4'b0010};
    logic [2:0] es[9] = '{3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2};
    logic       ep[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int j = 0;
    do_reset(2'b10, 4'h0);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (j < 9 && e == ed[j]) begin
        ncmp++;
        if (lights !== el[j] || state_code !== es[j] || phase !== ep[j]) begin
          nbad++;
          $display("FAIL demand_switch edge %0d: lights=%b state=%0d phase=%0d, want %b/%0d/%0d",
                   e, lights, state_code, phase, el[j], es[j], ep[j]);
        end
        j++;
      end
    end
    req = 2'b00;
  endtask

  task automatic test_go_freeze();
    int         ed[7] = '{14, 15, 16, 18, 20, 21, 22};
    logic [3:0] el[7] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1010};
    logic [2:0] es[7] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
    logic       ep[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int j = 0;
    do_reset(2'b10, 4'h0);
    for (int e = 1; e <= 23; e++) begin
      @(posedge clk); #1;
      if (j < 7 && e == ed[j]) begin
        ncmp++;
        if (lights !== el[j] || state_code !== es[j] || phase !== ep[j]) begin
          nbad++;
          $display("FAIL go_freeze edge %0d: lights=%b state=%0d phase=%0d, want %b/%0d/%0d",
                   e, lights, state_code, phase, el[j], es[j], ep[j]);
        end
        j++;
      end
      if (e == 15) go = 1'b0;
      if (e == 20) go = 1'b1;
    end
    req = 2'b00;
  endtask

  task automatic test_round_robin4();
    int         ed[8] = '{21, 30, 31, 34, 38, 48, 51, 55};
    logic [7:0] el[8] = '{8'hA2, 8'hA2, 8'hA6, 8'hAA, 8'h2A, 8'h6A, 8'hAA, 8'hA8};
    logic [2:0] es[8] = '{3'd2, 3'd2, 3'd3, 3'd0, 3'd2, 3'd3, 3'd0, 3'd2};
    logic [1:0] ep[8] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    int j = 0;
    do_reset(2'b00, 4'b0010);
    for (int e = 1; e <= 55; e++) begin
      @(posedge clk); #1;
      if (j < 8 && e == ed[j]) begin
        ncmp++;
        if (lights4 !== el[j] || state4 !== es[j] || phase4 !== ep[j]) begin
          nbad++;
          $display("FAIL round_robin4 edge %0d: lights4=%h state=%0d phase=%0d, want %h/%0d/%0d",
                   e, lights4, state4, phase4, el[j], es[j], ep[j]);
        end
        j++;
      end
      if (e == 5)  req4 = 4'b0000;
      if (e == 22) req4 = 4'b1001;
      if (e == 23) req4 = 4'b0000;
    end
  endtask

  task automatic test_async_reset();
    do_reset(2'b00, 4'h0);
    repeat (8) @(posedge clk);
    #1;
    ncmp++;
    if (lights !== 4'b1000 || state_code !== 3'd2) begin
      nbad++;
      $display("FAIL async_pre edge 8: lights=%b state=%0d, want 1000/2", lights, state_code);
    end
    #2 rst = 1'b0;
    #1;
    ncmp++;
    if (lights !== 4'b1010 || state_code !== 3'd0 || phase !== 1'b0 || lights4 !== 8'hAA) begin
      nbad++;
      $display("FAIL async_reset: lights=%b state=%0d phase=%0d lights4=%h, want 1010/0/0/aa",
               lights, state_code, phase, lights4);
    end
    @(negedge clk); rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e == 2 || e == 4) begin
        ncmp++;
        if (lights !== ((e == 2) ? 4'b1011 : 4'b1000)) begin
          nbad++;
          $display("FAIL async_restart edge %0d: lights=%b, want %b", e, lights, (e == 2) ? 4'b1011 : 4'b1000);
        end
      end
    end
  endtask

`ifdef TLC_FLASH_EN
  task automatic test_flash();
    int         ed[9] = '{7, 10, 11, 14, 15, 16, 17, 18, 19};
    logic [3:0] el[9] = '{4'b0101, 4'b0101, 4'b1010, 4'b1010, 4'b0101, 4'b0101, 4'b1010, 4'b1010, 4'b1011};
    logic [2:0] es[9] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd1};
    int j = 0;
    do_reset(2'b00, 4'h0);
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk); #1;
      if (j < 9 && e == ed[j]) begin
        ncmp++;
        if (lights !== el[j] || state_code !== es[j] || phase !== 1'b0) begin
          nbad++;
          $display("FAIL flash edge %0d: lights=%b state=%0d phase=%0d, want %b/%0d/0",
                   e, lights, state_code, phase, el[j], es[j]);
        end
        j++;
      end
      if (e == 6)  flash = 1'b1;
      if (e == 16) flash = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rest_green();
    test_demand_switch();
    test_go_freeze();
    test_round_robin4();
    test_async_reset();
`ifdef TLC_FLASH_EN
    test_flash();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
